// File: rtl/branch_control_unit_if.sv
// Branch-decision bus between execute-stage control and the branch control unit.
// The decode/ALU side drives the i_* signals and the unit returns decision and statistics.
interface branch_control_unit_if #(
    parameter int CNT_W = 32
);
    logic             i_Branch;
    logic             i_Z;
    logic             i_Res;
    logic [2:0]       i_f3;
    logic             i_CntClr;
    logic             o_DoBranch;
    logic             o_DoBranch_q;
    logic             o_IllegalF3;
    logic [CNT_W-1:0] o_TakenCnt;
    logic [CNT_W-1:0] o_NotTakenCnt;
    logic [CNT_W-1:0] o_IllegalCnt;

    modport master (
        output i_Branch, i_Z, i_Res, i_f3, i_CntClr,
        input  o_DoBranch, o_DoBranch_q, o_IllegalF3,
        input  o_TakenCnt, o_NotTakenCnt, o_IllegalCnt
    );

    modport slave (
        input  i_Branch, i_Z, i_Res, i_f3, i_CntClr,
        output o_DoBranch, o_DoBranch_q, o_IllegalF3,
        output o_TakenCnt, o_NotTakenCnt, o_IllegalCnt
    );
endinterface

// File: rtl/branch_control_unit.sv
// RISC-V conditional-branch decision: combinational take/illegal outputs, a registered
// copy of the decision and saturating taken / not-taken / illegal event counters.
module branch_control_unit #(
    parameter int CNT_W = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    branch_control_unit_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             do_branch;
    logic             f3_legal;
    logic             do_branch_q;
    logic [CNT_W-1:0] taken_q;
    logic [CNT_W-1:0] not_taken_q;
    logic [CNT_W-1:0] illegal_q;

    // BEQ/BNE look only at Z; the four compare encodings look only at Res.
    always_comb begin
        do_branch = 1'b0;
        f3_legal  = 1'b1;
        case (bus.i_f3)
            3'b000:          do_branch = bus.i_Z;
            3'b001:          do_branch = ~bus.i_Z;
            3'b100, 3'b110:  do_branch = bus.i_Res;
            3'b101, 3'b111:  do_branch = ~bus.i_Res;
            default:         f3_legal  = 1'b0;
        endcase
        if (!bus.i_Branch) do_branch = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            do_branch_q <= 1'b0;
            taken_q     <= '0;
            not_taken_q <= '0;
            illegal_q   <= '0;
        end else begin
            do_branch_q <= do_branch;
            if (bus.i_CntClr) begin
                taken_q     <= '0;
                not_taken_q <= '0;
                illegal_q   <= '0;
            end else if (bus.i_Branch) begin
                // Exactly one event class per branch cycle; each counter sticks at all-ones.
                if (do_branch) begin
                    if (taken_q != CNT_MAX) taken_q <= taken_q + CNT_ONE;
                end else if (f3_legal) begin
                    if (not_taken_q != CNT_MAX) not_taken_q <= not_taken_q + CNT_ONE;
                end else begin
                    if (illegal_q != CNT_MAX) illegal_q <= illegal_q + CNT_ONE;
                end
            end
        end
    end

    assign bus.o_DoBranch    = do_branch;
    assign bus.o_IllegalF3   = bus.i_Branch & ~f3_legal;
    assign bus.o_DoBranch_q  = do_branch_q;
    assign bus.o_TakenCnt    = taken_q;
    assign bus.o_NotTakenCnt = not_taken_q;
    assign bus.o_IllegalCnt  = illegal_q;
endmodule

// File: tb/tb_branch_control_unit.sv
// Bench for branch_control_unit: a 32-bit and a 2-bit counter instance share one stimulus
// stream and are checked every cycle against a behavioural model plus directed literals.
module tb_branch_control_unit;
    logic i_clk  = 1'b0;
    logic i_rstn = 1'b0;
    always #5 i_clk = ~i_clk;

    logic       br = 1'b0, z = 1'b0, res = 1'b0, clr = 1'b0;
    logic [2:0] f3 = 3'b000;

    branch_control_unit_if #(.CNT_W(32)) if32 ();
    branch_control_unit_if #(.CNT_W(2))  if2  ();

    assign if32.i_Branch = br;  assign if2.i_Branch = br;
    assign if32.i_Z      = z;   assign if2.i_Z      = z;
    assign if32.i_Res    = res; assign if2.i_Res    = res;
    assign if32.i_f3     = f3;  assign if2.i_f3     = f3;
    assign if32.i_CntClr = clr; assign if2.i_CntClr = clr;

    branch_control_unit #(.CNT_W(32)) dut32 (.i_clk(i_clk), .i_rstn(i_rstn), .bus(if32));
    branch_control_unit #(.CNT_W(2))  dut2  (.i_clk(i_clk), .i_rstn(i_rstn), .bus(if2));

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model state: event tallies per instance, clipped at each instance's maximum.
    longint unsigned m_taken [2];
    longint unsigned m_nt    [2];
    longint unsigned m_ill   [2];
    longint unsigned m_max   [2];
    bit              m_dq;

    initial begin
        m_max[0] = 64'hFFFF_FFFF;
        m_max[1] = 64'd3;
    end

    // funct3 bit2 selects the compare (Res) vs equality (Z) flag, bit0 inverts the sense.
    function automatic bit exp_do(input bit b, input bit zz, input bit rr, input logic [2:0] ff);
        bit legal;
        legal = ff[2] | ~ff[1];
        return b && legal && ((ff[2] ? rr : zz) ^ ff[0]);
    endfunction

    function automatic bit exp_ill(input bit b, input logic [2:0] ff);
        return b && (ff[2:1] == 2'b01);
    endfunction

    always @(posedge i_clk) begin
        if (!i_rstn) begin
            m_dq = 1'b0;
            for (int k = 0; k < 2; k++) begin
                m_taken[k] = 0; m_nt[k] = 0; m_ill[k] = 0;
            end
        end else begin
            m_dq = exp_do(br, z, res, f3);
            for (int k = 0; k < 2; k++) begin
                if (clr) begin
                    m_taken[k] = 0; m_nt[k] = 0; m_ill[k] = 0;
                end else if (br) begin
                    if (exp_do(br, z, res, f3)) begin
                        if (m_taken[k] < m_max[k]) m_taken[k]++;
                    end else if (!exp_ill(br, f3)) begin
                        if (m_nt[k] < m_max[k]) m_nt[k]++;
                    end else begin
                        if (m_ill[k] < m_max[k]) m_ill[k]++;
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge i_clk) begin
        if (chk_en) begin
            chk("m32_do",    64'(if32.o_DoBranch),    64'(exp_do(br, z, res, f3)));
            chk("m32_ill",   64'(if32.o_IllegalF3),   64'(exp_ill(br, f3)));
            chk("m32_dq",    64'(if32.o_DoBranch_q),  64'(m_dq));
            chk("m32_taken", 64'(if32.o_TakenCnt),    m_taken[0]);
            chk("m32_nt",    64'(if32.o_NotTakenCnt), m_nt[0]);
            chk("m32_illc",  64'(if32.o_IllegalCnt),  m_ill[0]);
            chk("m2_do",     64'(if2.o_DoBranch),     64'(exp_do(br, z, res, f3)));
            chk("m2_ill",    64'(if2.o_IllegalF3),    64'(exp_ill(br, f3)));
            chk("m2_dq",     64'(if2.o_DoBranch_q),   64'(m_dq));
            chk("m2_taken",  64'(if2.o_TakenCnt),     m_taken[1]);
            chk("m2_nt",     64'(if2.o_NotTakenCnt),  m_nt[1]);
            chk("m2_illc",   64'(if2.o_IllegalCnt),   m_ill[1]);
        end
    end

    // Applies one cycle of inputs; optional literal checks of the combinational outputs
    // mid-cycle; returns just after the edge that consumed the inputs.
    task automatic drive(input bit b, input bit zz, input bit rr, input logic [2:0] ff,
                         input bit c, input bit rn, input int lit_do, input int lit_ill);
        br = b; z = zz; res = rr; f3 = ff; clr = c; i_rstn = rn;
        @(negedge i_clk);
        if (lit_do >= 0) begin
            chk("lit_do32", 64'(if32.o_DoBranch), 64'(lit_do));
            chk("lit_do2",  64'(if2.o_DoBranch),  64'(lit_do));
        end
        if (lit_ill >= 0) chk("lit_ill", 64'(if32.o_IllegalF3), 64'(lit_ill));
        @(posedge i_clk);
        #1;
    endtask

    task automatic lit_regs32(input string nm, input int dq, input int t, input int n, input int il);
        chk({nm, "_dq"},    64'(if32.o_DoBranch_q),  64'(dq));
        chk({nm, "_taken"}, 64'(if32.o_TakenCnt),    64'(t));
        chk({nm, "_nt"},    64'(if32.o_NotTakenCnt), 64'(n));
        chk({nm, "_ill"},   64'(if32.o_IllegalCnt),  64'(il));
    endtask

    task automatic lit_regs2(input string nm, input int t, input int n, input int il);
        chk({nm, "_taken2"}, 64'(if2.o_TakenCnt),    64'(t));
        chk({nm, "_nt2"},    64'(if2.o_NotTakenCnt), 64'(n));
        chk({nm, "_ill2"},   64'(if2.o_IllegalCnt),  64'(il));
    endtask

    typedef struct {
        logic [2:0] f3;
        bit         z;
        bit         res;
        int         exp;
    } vec_t;

    vec_t sweep [12];

    initial begin
        sweep[0]  = '{3'b000, 1'b0, 1'b1, 0};  sweep[1]  = '{3'b000, 1'b1, 1'b0, 1};
        sweep[2]  = '{3'b001, 1'b1, 1'b0, 0};  sweep[3]  = '{3'b001, 1'b0, 1'b1, 1};
        sweep[4]  = '{3'b100, 1'b1, 1'b0, 0};  sweep[5]  = '{3'b100, 1'b0, 1'b1, 1};
        sweep[6]  = '{3'b110, 1'b1, 1'b0, 0};  sweep[7]  = '{3'b110, 1'b0, 1'b1, 1};
        sweep[8]  = '{3'b101, 1'b0, 1'b1, 0};  sweep[9]  = '{3'b101, 1'b1, 1'b0, 1};
        sweep[10] = '{3'b111, 1'b0, 1'b1, 0};  sweep[11] = '{3'b111, 1'b1, 1'b0, 1};

        // Reset for two edges with branch idle and other inputs busy.
        drive(1'b0, 1'b1, 1'b1, 3'b101, 1'b0, 1'b0, 0, 0);
        drive(1'b0, 1'b0, 1'b1, 3'b010, 1'b0, 1'b0, 0, 0);
        chk_en = 1'b1;
        lit_regs32("reset", 0, 0, 0, 0);

        // Branch idle: never taken, never illegal, no counting.
        drive(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 0, 0);
        drive(1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 1'b1, 0, 0);
        drive(1'b0, 1'b1, 1'b1, 3'b011, 1'b0, 1'b1, 0, 0);
        lit_regs32("idle", 0, 0, 0, 0);

        // Legal funct3 sweep, the unused flag held opposite to the used one.
        foreach (sweep[i])
            drive(1'b1, sweep[i].z, sweep[i].res, sweep[i].f3, 1'b0, 1'b1, sweep[i].exp, 0);
        lit_regs32("sweep", 1, 6, 6, 0);
        lit_regs2("sweep", 3, 3, 0);

        // Illegal encodings with all flag combinations; counter steps once per clock.
        drive(1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, i[0], i[1], (i < 4) ? 3'b010 : 3'b011, 1'b0, 1'b1, 0, 1);
            chk("illstep", 64'(if32.o_IllegalCnt), 64'(i + 1));
        end

        // Mixed sequence: 3 taken BEQ, 2 not-taken BNE, 1 illegal, 1 idle.
        drive(1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1, 0, 0);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 1, 0);
        chk("dq_after_beq", 64'(if32.o_DoBranch_q), 64'd1);
        for (int i = 0; i < 2; i++) drive(1'b1, 1'b1, 1'b1, 3'b001, 1'b0, 1'b1, 0, 0);
        chk("dq_after_bne", 64'(if32.o_DoBranch_q), 64'd0);
        drive(1'b1, 1'b1, 1'b0, 3'b010, 1'b0, 1'b1, 0, 1);
        drive(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 0, 0);
        lit_regs32("mix", 0, 3, 2, 1);
        lit_regs2("mix", 3, 2, 1);

        // Saturation of the 2-bit instance, then a one-clock clear.
        drive(1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1, 0, 0);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b1, 3'b100, 1'b0, 1'b1, 1, 0);
        drive(1'b1, 1'b0, 1'b0, 3'b100, 1'b0, 1'b1, 0, 0);
        lit_regs32("sat", 0, 5, 1, 0);
        lit_regs2("sat", 3, 1, 0);
        drive(1'b1, 1'b1, 1'b0, 3'b000, 1'b1, 1'b1, 1, 0);
        lit_regs32("clr", 1, 0, 0, 0);
        lit_regs2("clr", 0, 0, 0);

        // Reset mid-stream while a taken branch is presented.
        drive(1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 1, 0);
        drive(1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 1, 0);
        drive(1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1, 0);
        lit_regs32("midrst", 0, 0, 0, 0);
        lit_regs2("midrst", 0, 0, 0);
        drive(1'b1, 1'b0, 1'b0, 3'b101, 1'b0, 1'b1, 1, 0);
        lit_regs32("postrst", 1, 1, 0, 0);
        drive(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 0, 0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/branch_control_unit.md
Name: branch_control_unit

Overview:
- Conditional-branch decision block in the execute stage of the RISC-V core.
- Evaluates funct3 of a branch instruction against the ALU zero flag (i_Z) and the ALU compare result (i_Res). Drives a combinational take-branch signal to PC select.
- Also provides a registered copy of the decision, an illegal-funct3 flag and saturating taken/not-taken/illegal event counters for performance monitoring.

Parameters:
- CNT_W, 32, width of each event counter (legal range 1..64).

Ports:
- i_clk  in  1  system clock; all state updates on its rising edge.
- i_rstn  in  1  synchronous, active-low reset.
- i_Branch  in  1  current instruction is a conditional branch (decode control).
- i_Z  in  1  ALU zero flag: 1 when rs1 == rs2 (ALU subtract result zero).
- i_Res  in  1  ALU compare result: 1 when rs1 < rs2 (signed for BLT/BGE, unsigned for BLTU/BGEU; the ALU selects the compare).
- i_f3  in  3  instruction funct3.
- i_CntClr  in  1  synchronous clear of all counters.
- o_DoBranch  out  1  combinational take-branch decision.
- o_DoBranch_q  out  1  o_DoBranch registered one cycle.
- o_IllegalF3  out  1  combinational: i_Branch=1 and i_f3 is not a branch encoding.
- o_TakenCnt  out  CNT_W  count of taken branches.
- o_NotTakenCnt  out  CNT_W  count of legal branches not taken.
- o_IllegalCnt  out  CNT_W  count of cycles with o_IllegalF3=1.

Behaviour:
- Combinational decision, zero latency, independent of clock and reset:
  - i_Branch=0: o_DoBranch=0 and o_IllegalF3=0 for any other input.
  - i_Branch=1, i_f3=000 (BEQ): o_DoBranch = i_Z.
  - 001 (BNE): o_DoBranch = ~i_Z.
  - 100 (BLT) and 110 (BLTU): o_DoBranch = i_Res.
  - 101 (BGE) and 111 (BGEU): o_DoBranch = ~i_Res.
  - 010 and 011: o_DoBranch=0, o_IllegalF3=1.
- i_Z is ignored for the compare encodings; i_Res is ignored for BEQ/BNE.
- Registered state, updated only on the rising edge of i_clk:
  - If i_rstn=0: o_DoBranch_q=0 and all counters=0. Reset has priority over everything.
  - Else if i_CntClr=1: all counters=0. o_DoBranch_q still loads o_DoBranch.
  - Else: o_DoBranch_q loads o_DoBranch, and exactly one counter updates per cycle when i_Branch=1:
    - o_TakenCnt +1 if o_DoBranch=1.
    - else o_NotTakenCnt +1 if f3 is legal.
    - else o_IllegalCnt +1.
  - i_Branch=0: no counter changes.
- Counters saturate at 2^CNT_W-1 and never wrap. A saturated counter holds while the others keep counting.
- Asserting reset mid-operation clears all state on that edge. Combinational outputs continue to follow their inputs during reset.
- Inputs are sampled as-is; no X-propagation masking is required.

Test Plan:
- i_rstn=0 for 2 clocks, then 1 -> o_DoBranch_q=0, all counters=0. With i_Branch=0 and any i_Z/i_Res/i_f3 -> o_DoBranch=0, o_IllegalF3=0.
- i_Branch=1, sweep each legal f3 with the flag at 0 then 1 (10 ns per step):
  - BEQ Z=0/1 -> 0/1.
  - BNE Z=1/0 -> 0/1.
  - BLT Res=0/1 -> 0/1.
  - BLTU Res=0/1 -> 0/1.
  - BGE Res=1/0 -> 0/1.
  - BGEU Res=1/0 -> 0/1.
- i_Branch=1, f3=010 then 011, with i_Z and i_Res in all four combinations -> o_DoBranch=0, o_IllegalF3=1. o_IllegalCnt increments once per clock.
- Clocked sequence of 3 taken BEQ, 2 not-taken BNE, 1 illegal f3=010, 1 cycle with i_Branch=0 -> Taken=3, NotTaken=2, Illegal=1. o_DoBranch_q equals the previous cycle's o_DoBranch.
- CNT_W=2: 5 taken branches -> o_TakenCnt sticks at 3. Then i_CntClr=1 for one clock -> all counters=0.
- Assert i_rstn=0 for one clock mid-sequence while i_Branch=1 -> counters and o_DoBranch_q=0 after that edge. o_DoBranch still follows its inputs.
